// File: rtl/phy_rx_core.sv
// Serial-link receiver: hunts for COMMA byte alignment, locks after LOCK_COUNT aligned commas,
// then splits the byte stream into four rotating lanes and presents one frame every 32 bits.
module phy_rx_core #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       frame_stb,
  output logic       active,
  output logic       idle
);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_SYNC  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [1:0] slot_ptr_q, slot_ptr_d;
  logic [7:0] lane_reg_q [4];
  logic [7:0] lane_reg_d [4];
  logic [3:0] lane_vld_q, lane_vld_d;
  logic [7:0] data_q [4];
  logic [7:0] data_d [4];
  logic [3:0] vld_q, vld_d;
  logic       stb_q, stb_d;
  logic       active_q, active_d;
  logic       idle_q, idle_d;

  logic [7:0] window;
  logic [3:0] bc_inc;
  logic       byte_vld;

  // The window sees the bit arriving on this edge, so a byte is complete when bit_cnt is 7.
  assign window   = {sr_q[6:0], serial_in};
  assign bc_inc   = bc_cnt_q + 4'd1;
  assign byte_vld = (window != COMMA);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d    = state_q;
    sr_d       = window;
    bit_cnt_d  = bit_cnt_q;
    bc_cnt_d   = bc_cnt_q;
    slot_ptr_d = slot_ptr_q;
    lane_reg_d = lane_reg_q;
    lane_vld_d = lane_vld_q;
    data_d     = data_q;
    vld_d      = vld_q;
    stb_d      = 1'b0;
    active_d   = active_q;
    idle_d     = idle_q;

    case (state_q)
      ST_HUNT: begin
        if (window == COMMA) begin
          bc_cnt_d  = 4'd1;
          bit_cnt_d = 3'd0;
          state_d   = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (window == COMMA) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == 4'(LOCK_COUNT)) begin
              state_d    = ST_SYNC;
              active_d   = 1'b1;
              slot_ptr_d = 2'd0;
              bit_cnt_d  = 3'd0;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = ST_HUNT;
          end
        end
      end
      ST_SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          lane_reg_d[slot_ptr_q] = window;
          lane_vld_d[slot_ptr_q] = byte_vld;
          slot_ptr_d             = slot_ptr_q + 2'd1;
          // Lane 3 bypasses its holding register so the frame appears on the edge that completes it.
          if (slot_ptr_q == 2'd3) begin
            data_d[0] = lane_reg_q[0];
            data_d[1] = lane_reg_q[1];
            data_d[2] = lane_reg_q[2];
            data_d[3] = window;
            vld_d     = {byte_vld, lane_vld_q[2:0]};
            stb_d     = 1'b1;
            idle_d    = ~(byte_vld | (|lane_vld_q[2:0]));
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // NOTE: all state, including the small lane holding array, is cleared by the async reset so a
  // mid-operation reset leaves nothing stale on the outputs; updates are non-blocking (<=).
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      bc_cnt_q   <= '0;
      slot_ptr_q <= '0;
      lane_reg_q <= '{default: '0};
      lane_vld_q <= '0;
      data_q     <= '{default: '0};
      vld_q      <= '0;
      stb_q      <= 1'b0;
      active_q   <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      slot_ptr_q <= slot_ptr_d;
      lane_reg_q <= lane_reg_d;
      lane_vld_q <= lane_vld_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      stb_q      <= stb_d;
      active_q   <= active_d;
      idle_q     <= idle_d;
    end
  end

  assign data_out0  = data_q[0];
  assign data_out1  = data_q[1];
  assign data_out2  = data_q[2];
  assign data_out3  = data_q[3];
  assign valid_out0 = vld_q[0];
  assign valid_out1 = vld_q[1];
  assign valid_out2 = vld_q[2];
  assign valid_out3 = vld_q[3];
  assign frame_stb  = stb_q;
  assign active     = active_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_phy_rx_core.sv
// Directed bench for phy_rx_core: lock, frame decode, offset lock, lock loss and async reset.
module tb_phy_rx_core;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       frame_stb, active, idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stb_count = 0;
  int last_stb_cyc = 0;
  int stb_gap = 0;

  phy_rx_core dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .frame_stb  (frame_stb),
    .active     (active),
    .idle       (idle)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one bit, lets the next rising edge sample it, and returns 1 time unit after it.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk_32f);
    #1;
    cyc++;
    if (frame_stb === 1'b1) begin
      stb_count++;
      stb_gap      = cyc - last_stb_cyc;
      last_stb_cyc = cyc;
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic hold_reset();
    reset     = 1'b0;
    serial_in = 1'b1;
    repeat (5) @(posedge clk_32f);
    #1;
  endtask

  task automatic release_reset();
    reset     = 1'b1;
    stb_count = 0;
  endtask

  function automatic logic [31:0] data_all();
    return {data_out3, data_out2, data_out1, data_out0};
  endfunction

  function automatic logic [31:0] vld_all();
    return {28'd0, valid_out3, valid_out2, valid_out1, valid_out0};
  endfunction

  initial begin
    // 1: reset held with serial_in high
    hold_reset();
    check("rst_data", data_all(), 32'h0);
    check("rst_valid", vld_all(), 32'h0);
    check("rst_stb", {31'd0, frame_stb}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd0);

    // 2: aligned lock on the 4th comma (bit 31)
    release_reset();
    repeat (3) send_byte(8'hBC);
    send_bits(8'h5E, 7);
    check("lock_before_bit31", {31'd0, active}, 32'd0);
    send_bit(1'b0);
    check("lock_at_bit31", {31'd0, active}, 32'd1);
    check("lock_no_stb", stb_count, 32'd0);

    // 3: data frame then an all-comma frame
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'hBC);
    send_bits(8'h22, 7);
    check("frame1_not_yet", stb_count, 32'd0);
    send_bit(1'b0);
    check("frame1_stb", {31'd0, frame_stb}, 32'd1);
    check("frame1_data", data_all(), 32'h44BC2211);
    check("frame1_valid", vld_all(), 32'b1011);
    check("frame1_idle", {31'd0, idle}, 32'd0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("hold_between_stb", data_all(), 32'h44BC2211);
    check("stb_one_cycle", stb_count, 32'd1);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("frame2_stb", {31'd0, frame_stb}, 32'd1);
    check("frame2_valid", vld_all(), 32'b0000);
    check("frame2_idle", {31'd0, idle}, 32'd1);
    check("frame2_data", data_all(), 32'hBCBCBCBC);
    check("stb_period", stb_gap, 32'd32);
    check("stb_total", stb_count, 32'd2);

    // 4: three leading bits shift alignment and lock by 3 cycles
    hold_reset();
    release_reset();
    send_bits(8'h05, 3);
    repeat (3) send_byte(8'hBC);
    send_bits(8'h5E, 7);
    check("ofs_lock_before", {31'd0, active}, 32'd0);
    send_bit(1'b0);
    check("ofs_lock_at_bit34", {31'd0, active}, 32'd1);
    send_byte(8'hBC);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'hC3);
    check("ofs_stb", {31'd0, frame_stb}, 32'd1);
    check("ofs_data", data_all(), 32'hC3A55ABC);
    check("ofs_valid", vld_all(), 32'b1110);
    check("ofs_idle", {31'd0, idle}, 32'd0);

    // 5: a non-comma during alignment restarts the hunt
    hold_reset();
    release_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    check("break_after_55", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    check("break_no_stale_count", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("break_3_commas", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    check("break_relock", {31'd0, active}, 32'd1);
    check("break_no_stb", stb_count, 32'd0);

    // 6: async reset mid-byte while locked
    hold_reset();
    release_reset();
    repeat (4) send_byte(8'hBC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("pre_rst_data", data_all(), 32'h44332211);
    send_byte(8'h66);
    send_byte(8'h77);
    send_bits(8'h05, 3);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_active", {31'd0, active}, 32'd0);
    check("async_rst_data", data_all(), 32'h0);
    check("async_rst_valid", vld_all(), 32'h0);
    @(posedge clk_32f);
    #1;
    release_reset();
    repeat (3) send_byte(8'hBC);
    check("relock_3_commas", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    check("relock_4_commas", {31'd0, active}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
